pool_out_writer: RTL and testbench

//   Stream sink at the far end of the pooling output (s_data/s_valid/s_ready).

---
 rtl/pool_out_writer.sv | 198 +++++++++++++++++++
 tb/tb_pool_out_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_out_writer.sv
// Pool-stage output sink: takes handshaked DN-lane words and writes them to one
// feature-RAM bank at consecutive addresses, then pulses done once the count is stored.
module pool_out_writer #(
  parameter int DW = 8,
  parameter int DN = 7,
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [AW-1:0]    cfg_base,
  input  logic [AW-1:0]    cfg_len,
  input  logic             cfg_bank,
  input  logic [DN*DW-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             wr_en,
  input  logic             wr_gnt,
  output logic             wr_bank,
  output logic [AW-1:0]    wr_addr,
  output logic [DN*DW-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int WW = DN * DW;

  // Handshake: a word moves on s_* when s_valid && s_ready at a rising edge;
  // a RAM write completes when wr_en && wr_gnt at a rising edge, and wr_* hold
  // their values until then.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   len_q, len_d;
  logic            bank_q, bank_d;
  logic [AW-1:0]   count_q, count_d;
  logic            wr_en_q, wr_en_d;
  logic            wr_bank_q, wr_bank_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [WW-1:0]   wr_data_q, wr_data_d;
  logic            ovf_q, ovf_d;

  logic            s_ready_c;
  logic            busy_c;
  logic            done_c;
  logic            start_ok;
  logic            accept;
  logic            wr_done;
  logic [AW-1:0]   count_inc;
  logic            last_word;

  assign start_ok  = cfg_start && (state_q == S_IDLE);
  assign accept    = s_valid && s_ready_c;
  assign wr_done   = wr_en_q && wr_gnt;
  assign count_inc = count_q + AW'(1);
  assign last_word = (count_inc == len_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = (cfg_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && last_word) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wr_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; the pending write slot frees up in the same cycle it is granted
  always_comb begin
    s_ready_c = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        s_ready_c = 1'b0;
      end
      S_RUN: begin
        s_ready_c = !wr_en_q || wr_gnt;
        busy_c    = 1'b1;
      end
      S_DRAIN: begin
        busy_c    = 1'b1;
      end
      S_DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
      end
      default: begin
        s_ready_c = 1'b0;
      end
    endcase
  end

  // Datapath next-state
  always_comb begin
    base_d    = base_q;
    len_d     = len_q;
    bank_d    = bank_q;
    count_d   = count_q;
    wr_en_d   = wr_en_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;

    if (start_ok) begin
      base_d  = cfg_base;
      len_d   = cfg_len;
      bank_d  = cfg_bank;
      count_d = '0;
    end else if (accept) begin
      count_d = count_inc;
    end

    // Address arithmetic wraps modulo 2^AW by construction
    if (accept) begin
      wr_en_d   = 1'b1;
      wr_bank_d = bank_q;
      wr_addr_d = base_q + count_q;
      wr_data_d = s_data;
    end else if (wr_done) begin
      wr_en_d   = 1'b0;
    end

    if (start_ok) begin
      ovf_d = 1'b0;
    end else if ((state_q == S_IDLE) && s_valid) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      bank_q    <= 1'b0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      base_q    <= base_d;
      len_q     <= len_d;
      bank_q    <= bank_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign s_ready   = s_ready_c;
  assign busy      = busy_c;
  assign done      = done_c;
  assign wr_en     = wr_en_q;
  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pool_out_writer.sv
// Self-checking bench for pool_out_writer: directed vector table, random transfers,
// and hand-written sequences for IDLE overflow and mid-transfer reset.
module tb_pool_out_writer;

  localparam int DW   = 8;
  localparam int DN   = 7;
  localparam int AW   = 10;
  localparam int WORD = DN * DW;
  localparam int EW   = 1 + AW + WORD;

  logic            clk;
  logic            rst_n;
  logic            cfg_start;
  logic [AW-1:0]   cfg_base;
  logic [AW-1:0]   cfg_len;
  logic            cfg_bank;
  logic [WORD-1:0] s_data;
  logic            s_valid;
  logic            s_ready;
  logic            wr_en;
  logic            wr_gnt;
  logic            wr_bank;
  logic [AW-1:0]   wr_addr;
  logic [WORD-1:0] wr_data;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [1:0]      dbg_state;

  pool_out_writer #(.DW(DW), .DN(DN), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_base  (cfg_base),
    .cfg_len   (cfg_len),
    .cfg_bank  (cfg_bank),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_gnt    (wr_gnt),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int tests_run;
  int tests_failed;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WORD-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[WORD-1:0];
  endfunction

  // ---------------- driver: one whole transfer ----------------
  // gnt_mode: 0 always granted, 1 toggles 1010.., 2 random
  // vld_mode: 0 s_valid held high while busy, 1 random
  task automatic run_xfer(input logic [AW-1:0] base, input logic [AW-1:0] len,
                          input logic bank, input int gnt_mode, input int vld_mode,
                          input int exp_lat, input int abort_after, input string name);
    logic [WORD-1:0] words[$];
    logic [WORD-1:0] w;
    logic [AW-1:0]   a;
    logic [EW-1:0]   got;
    logic [EW-1:0]   exp;
    logic [EW-1:0]   hold_val;
    logic            hold_pend;
    int idx, writes, done_cnt, done_cyc, last_wr_cyc, budget;
    bit aborted;

    words.delete();
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      w = rand_word();
      a = base + AW'(i);
      words.push_back(w);
      exp_q.push_back({bank, a, w});
    end
    idx = 0; writes = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
    hold_pend = 1'b0; hold_val = '0; aborted = 1'b0;
    budget = 20 * int'(len) + 60;

    @(negedge clk);
    cfg_start = 1'b1; cfg_base = base; cfg_len = len; cfg_bank = bank;
    s_valid = 1'b0; s_data = rand_word(); wr_gnt = 1'b0;

    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      // Configuration inputs are scrambled after the start: the DUT must use its latched copy
      cfg_start = busy && !done && ($urandom_range(0, 7) == 0);
      cfg_base  = AW'($urandom());
      cfg_len   = AW'($urandom());
      cfg_bank  = 1'($urandom());
      if (busy && !done && (vld_mode == 0 || $urandom_range(0, 2) != 0)) begin
        s_valid = 1'b1;
        s_data  = (idx < int'(len)) ? words[idx] : rand_word();
      end else begin
        s_valid = 1'b0;
        s_data  = rand_word();
      end
      case (gnt_mode)
        0:       wr_gnt = 1'b1;
        1:       wr_gnt = cyc[0];
        default: wr_gnt = 1'($urandom());
      endcase
      #1;
      check_eq({name, ":ovf"}, ovf, 1'b0);
      if (hold_pend) check_eq({name, ":hold"}, {wr_en, wr_bank, wr_addr, wr_data}, {1'b1, hold_val});
      if (wr_en && !wr_gnt) check_eq({name, ":ready_stall"}, s_ready, 1'b0);
      if (wr_en && wr_gnt) begin
        writes++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq({name, ":write_count"}, writes, len);
        end else begin
          got = {wr_bank, wr_addr, wr_data};
          exp = exp_q.pop_front();
          check_eq({name, ":write"}, got, exp);
        end
      end
      if (s_valid && s_ready) idx++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq({name, ":done_busy"}, {busy, wr_en}, 2'b10);
        if (len != '0) check_eq({name, ":done_after_write"}, cyc, last_wr_cyc + 1);
        break;
      end
      hold_pend = wr_en && !wr_gnt;
      hold_val  = {wr_bank, wr_addr, wr_data};
      if (abort_after >= 0 && writes >= abort_after) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0; s_valid = 1'b0; cfg_start = 1'b0; wr_gnt = 1'b0;
        #1;
        check_eq({name, ":reset_async"},
                 {s_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done, ovf, dbg_state}, '0);
        repeat (2) begin
          @(negedge clk);
          #1;
          check_eq({name, ":no_done_in_reset"}, {done, busy}, 2'b00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
    end

    if (!aborted) begin
      check_eq({name, ":done_seen"}, done_cnt, 1);
      check_eq({name, ":left_in_q"}, exp_q.size(), 0);
      if (exp_lat > 0) check_eq({name, ":latency"}, done_cyc, exp_lat);
      @(negedge clk);
      cfg_start = 1'b0; s_valid = 1'b0; wr_gnt = 1'b0;
      #1;
      check_eq({name, ":after_done"}, {busy, done, wr_en, s_ready}, 4'b0000);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic          bank;
    int            gnt_mode;
    int            vld_mode;
    int            exp_lat;
    string         name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_bank = 1'b0;
    s_data = '0; s_valid = 1'b0; wr_gnt = 1'b0;

    // Full throughput: start, len accepts one per cycle, drain write, then done
    vecs.push_back('{10'h010, 10'd4,    1'b1, 0, 0, 6,    "t1_stream"});
    vecs.push_back('{10'h010, 10'd4,    1'b1, 1, 0, 0,    "t2_gnt_toggle"});
    vecs.push_back('{10'h3FE, 10'd4,    1'b0, 0, 0, 6,    "t3_wrap"});
    vecs.push_back('{10'h123, 10'd0,    1'b1, 0, 0, 1,    "t4_len0"});
    vecs.push_back('{10'h200, 10'd1,    1'b0, 0, 0, 3,    "len1"});
    vecs.push_back('{10'h2FF, 10'd9,    1'b1, 1, 1, 0,    "toggle_rand_vld"});
    vecs.push_back('{10'h005, 10'd1023, 1'b0, 0, 0, 1025, "len_max"});

    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_state",
             {s_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done, ovf, dbg_state}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_xfer(vecs[i].base, vecs[i].len, vecs[i].bank, vecs[i].gnt_mode,
               vecs[i].vld_mode, vecs[i].exp_lat, -1, vecs[i].name);
    end

    // T5: s_valid in IDLE sets sticky ovf, is never written, start clears ovf
    @(negedge clk);
    s_valid = 1'b1; s_data = rand_word(); wr_gnt = 1'b1;
    #1;
    check_eq("t5_idle_ready", {s_ready, wr_en}, 2'b00);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check_eq("t5_ovf_set", {ovf, wr_en, busy}, 3'b100);
    @(negedge clk);
    #1;
    check_eq("t5_ovf_sticky", {ovf, wr_en}, 2'b10);
    run_xfer(10'h0A0, 10'd3, 1'b1, 2, 1, 0, -1, "t5_clear");

    // T6: reset after 2 of 5 writes, then a fresh full transfer
    run_xfer(10'h040, 10'd5, 1'b0, 0, 0, 0, 2, "t6_abort");
    run_xfer(10'h040, 10'd5, 1'b0, 0, 0, 7, -1, "t6_fresh");

    // Random transfers against the address/data model
    for (int n = 0; n < 25; n++) begin
      run_xfer(AW'($urandom()), AW'($urandom_range(0, 40)), 1'($urandom()),
               2, 1, 0, -1, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
